// File: rtl/jpeg_rle_block_decoder.sv
// Turns Huffman-decoded JPEG symbols (DC difference, AC run/size/amplitude) into one
// 64-coefficient zigzag-ordered block, keeping a DC predictor across blocks.
module jpeg_rle_block_decoder #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 64
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          dc_pred_clear,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  input  logic                          sym_is_dc,
  input  logic [3:0]                    sym_run,
  input  logic [3:0]                    sym_size,
  input  logic [DATA_WIDTH-1:0]         sym_amp,
  output logic                          block_valid,
  input  logic                          block_ready,
  output logic [DEPTH*DATA_WIDTH-1:0]   block_data,
  output logic                          block_error,
  output logic                          busy,
  output logic [1:0]                    state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and payload is held while valid is high.

  typedef enum logic [1:0] {
    S_DC  = 2'b00,
    S_AC  = 2'b01,
    S_OUT = 2'b10
  } state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] coef [DEPTH];
  logic [DATA_WIDTH-1:0] pred;
  logic [6:0]            idx;
  logic                  err;

  logic                  accept;
  logic                  size_ok;
  logic [DATA_WIDTH-1:0] amp_v;
  logic [DATA_WIDTH-1:0] dc_val;
  logic [6:0]            zrl_idx;
  logic [6:0]            pos;

  logic                  buf_wr;
  logic [5:0]            wr_idx;
  logic [DATA_WIDTH-1:0] wr_val;
  logic                  idx_load;
  logic [6:0]            idx_nxt;
  logic                  err_set;
  logic                  pred_load;
  logic                  buf_clear;

  // JPEG magnitude category decode: a leading 0 bit marks a negative value.
  function automatic logic [DATA_WIDTH-1:0] decode_amp(input logic [3:0] s,
                                                       input logic [DATA_WIDTH-1:0] amp);
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] raw;
    logic                  msb;
    mask = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      if (b < int'(s)) mask[b] = 1'b1;
    end
    raw = amp & mask;
    msb = |(amp & (mask ^ (mask >> 1)));
    if (s == 4'd0)  return '0;
    else if (msb)   return raw;
    else            return raw - mask;
  endfunction

  always_comb begin
    accept  = sym_valid & sym_ready;
    size_ok = (int'(sym_size) <= DATA_WIDTH);
    amp_v   = decode_amp(sym_size, sym_amp);
    // A clear in the same cycle as a DC symbol wins over the stored predictor.
    dc_val  = (dc_pred_clear ? '0 : pred) + amp_v;
    zrl_idx = idx + 7'd16;
    pos     = idx + {3'b000, sym_run};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_DC;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    sym_ready  = 1'b0;
    block_valid = 1'b0;
    buf_wr     = 1'b0;
    wr_idx     = pos[5:0];
    wr_val     = amp_v;
    idx_load   = 1'b0;
    idx_nxt    = idx;
    err_set    = 1'b0;
    pred_load  = 1'b0;
    buf_clear  = 1'b0;
    case (state)
      S_DC: begin
        sym_ready = 1'b1;
        if (accept) begin
          // Oversized DC categories cannot be decoded, so they are dropped like AC ones.
          if (!sym_is_dc || !size_ok) begin
            err_set = 1'b1;
          end else begin
            buf_wr     = 1'b1;
            wr_idx     = 6'd0;
            wr_val     = dc_val;
            pred_load  = 1'b1;
            idx_load   = 1'b1;
            idx_nxt    = 7'd1;
            next_state = S_AC;
          end
        end
      end
      S_AC: begin
        sym_ready = 1'b1;
        if (accept) begin
          if (sym_is_dc) begin
            err_set = 1'b1;
          end else if (sym_size == 4'd0) begin
            if (sym_run == 4'd0) begin
              next_state = S_OUT;
            end else if (sym_run == 4'd15) begin
              idx_load = 1'b1;
              idx_nxt  = zrl_idx;
              if (zrl_idx >= 7'd64) next_state = S_OUT;
              if (zrl_idx > 7'd64)  err_set = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end else if (!size_ok) begin
            err_set = 1'b1;
          end else if (pos > 7'd63) begin
            err_set    = 1'b1;
            next_state = S_OUT;
          end else begin
            buf_wr   = 1'b1;
            idx_load = 1'b1;
            idx_nxt  = pos + 7'd1;
            if (pos == 7'd63) next_state = S_OUT;
          end
        end
      end
      S_OUT: begin
        block_valid = 1'b1;
        if (block_ready) begin
          buf_clear  = 1'b1;
          next_state = S_DC;
        end
      end
      default: next_state = S_DC;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) coef[k] <= '0;
      pred <= '0;
      idx  <= '0;
      err  <= 1'b0;
    end else begin
      if (buf_clear) begin
        for (int k = 0; k < DEPTH; k++) coef[k] <= '0;
      end else if (buf_wr) begin
        coef[wr_idx] <= wr_val;
      end

      if (pred_load)          pred <= dc_val;
      else if (dc_pred_clear) pred <= '0;

      if (idx_load) idx <= idx_nxt;

      if (buf_clear)    err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign block_data[k*DATA_WIDTH +: DATA_WIDTH] = coef[k];
  end

  assign block_error = (state == S_OUT) & err;
  assign busy        = (state != S_DC);
  assign state_dbg   = state;

endmodule

// File: doc/jpeg_rle_block_decoder.md
Name: jpeg_rle_block_decoder

Overview:
Decode-side counterpart of the Huffman encode controller. It accepts already-Huffman-decoded JPEG symbols (DC difference, or AC run/size/amplitude) over a valid/ready handshake. It reconstructs DC from a running predictor, expands AC run-lengths, EOB and ZRL, and assembles one 64-coefficient block in zigzag order. The finished block is presented as a 640-bit word with a valid/ready handshake, feeding a de-zigzag buffer and then dequantize/IDCT.

Parameters:
DATA_WIDTH, 10, coefficient width in bits (two's complement); also the maximum legal symbol size.
DEPTH, 64, coefficients per block (fixed at 64; the index pointer is 7 bits).

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
dc_pred_clear  in  1  pulse: zero the DC predictor (restart marker / new component)
sym_valid  in  1  symbol present
sym_ready  out  1  decoder can accept a symbol this cycle
sym_is_dc  in  1  1 = DC difference symbol, 0 = AC symbol
sym_run  in  4  AC zero-run length (ignored for DC)
sym_size  in  4  category / amplitude bit count (0..DATA_WIDTH)
sym_amp  in  DATA_WIDTH  raw amplitude bits, right-aligned; bits at and above sym_size are ignored
block_valid  out  1  block_data holds a complete block
block_ready  in  1  downstream accepts the block
block_data  out  DEPTH*DATA_WIDTH  coefficients in zigzag order; index k at bits [k*DW +: DW]
block_error  out  1  the presented block saw at least one protocol error; qualified by block_valid
busy  out  1  high from DC accept until block handoff

Behaviour:
- Reset (async, reset_n=0):
  - State goes to S_DC; coefficient buffer, DC predictor, index and error flag are all zeroed.
  - Outputs: block_valid=0, block_error=0, busy=0, block_data=0, sym_ready=1 once reset is released.
- Symbol acceptance: a symbol is accepted on any edge where sym_valid & sym_ready. Exactly one symbol is consumed per cycle; no stalls inside a block.
- Amplitude decode (size s>0):
  - if amp[s-1]=1, v = amp[s-1:0] zero-extended;
  - else v = amp[s-1:0] - (2^s - 1).
  - Result is sign-correct in DATA_WIDTH bits.
- States:
  - S_DC (sym_ready=1):
    - Accept with is_dc=1: dc = pred + v (v=0 if s=0), wrapped to DATA_WIDTH. Then buf[0]=dc, pred=dc, idx=1, busy=1, go to S_AC.
    - Accept with is_dc=0: err=1, symbol dropped, stay in S_DC.
  - S_AC (sym_ready=1):
    - is_dc=1: err=1, symbol dropped.
    - run=0, size=0 (EOB): go to S_OUT; remaining coefficients stay 0.
    - run=15, size=0 (ZRL): idx=idx+16. If the new idx is 64, go to S_OUT. If it exceeds 64, set err=1 and go to S_OUT.
    - size=0 with any other run: err=1, symbol dropped.
    - size>DATA_WIDTH: err=1, symbol dropped.
    - size>0: pos = idx+run. If pos>63, set err=1 and go to S_OUT. Otherwise buf[pos]=v, idx=pos+1, and if idx reaches 64 go to S_OUT (implicit end, no EOB needed).
  - S_OUT (sym_ready=0, block_valid=1, block_error=err):
    - block_data is held stable until block_ready.
    - On block_ready: buffer cleared to 0, err=0, busy=0, go to S_DC.
    - The next symbol can be accepted the cycle after handoff.
- Latency: block_valid rises on the edge that accepts the terminating symbol, i.e. it is visible the cycle after the EOB handshake.
- dc_pred_clear:
  - Takes effect on the next edge in any state.
  - If asserted in the same cycle a DC symbol is accepted, that DC uses pred=0 (clear has priority), and pred ends equal to the decoded dc.
  - Does not disturb a block in progress.
- Wrap: DC predictor arithmetic wraps modulo 2^DATA_WIDTH; no saturation.
- Mid-block reset: the partial block is discarded, no block_valid is produced, and pred=0.

Test Plan:
- Amplitude/DC decode:
  - DC(s=4, amp=1010) → block[0]=+10, then EOB → block_valid next cycle, other 63 coefficients 0, block_error=0.
  - Next block DC(s=2, amp=01) → -2 diff → block[0]=+8.
- AC runs:
  - DC(s=0), AC(run=2, s=3, amp=010) → block[3]=-5.
  - Then AC(run=0, s=3, amp=101) → block[4]=+5.
  - Then EOB → all other coefficients 0.
- ZRL and full block:
  - DC, ZRL×3 (idx=49), AC(run=14, s=1, amp=1) → block[63]=+1.
  - Block completes with no EOB; sym_ready=0 in the next cycle.
- Overflow errors:
  - DC, ZRL×4 → idx would be 65 → S_OUT with block_error=1.
  - Separately, AC(run=15, s=1) at idx=50 → pos=65 → block_error=1.
- Handshake and protocol errors:
  - Hold block_ready=0 for 5 cycles → block_data stable, sym_ready=0.
  - AC symbol sent in S_DC → dropped, block_error=1 on the eventual block; cleared on the following block.
- Predictor clear / reset:
  - dc_pred_clear coincident with DC(s=3, amp=111) → block[0]=+7 regardless of the prior predictor.
  - reset_n pulse mid-block → no block emitted; the next DC decodes against pred=0.
